// File: rtl/tonegen_pkg.sv
// Shared definitions for the tone generator audio path: FSM state encoding,
// sample/attenuation limits and the dither LFSR constants.
package tonegen_pkg;

  localparam int          SAMPLE_W  = 16;
  localparam logic [3:0]  ATT_MAX   = 4'd15;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/dsm_mod.sv
// First-order delta-sigma modulator: 16-bit accumulator whose carry is the
// 1-bit DAC stream. Optional dither via a 16-bit Galois LFSR when
// TONEGEN_DITHER_EN is defined; otherwise the offset-binary sample feeds
// the accumulator directly.
module dsm_mod
  import tonegen_pkg::*;
(
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [SAMPLE_W-1:0] u_in,
  output logic                dac_out
);

  logic [SAMPLE_W:0]   acc;
  logic [SAMPLE_W-1:0] mod_in;

`ifdef TONEGEN_DITHER_EN
  logic [15:0]       lfsr;
  logic [SAMPLE_W:0] dith_sum;

  // Free-running Galois LFSR providing two bits of dither per clock
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) lfsr <= LFSR_SEED;
    else             lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Add dither to the sample, clamping at full scale so it cannot wrap
  always_comb begin
    dith_sum = {1'b0, u_in} + {{(SAMPLE_W-1){1'b0}}, lfsr[1:0]};
    mod_in   = dith_sum[SAMPLE_W] ? '1 : dith_sum[SAMPLE_W-1:0];
  end
`else
  assign mod_in = u_in;
`endif

  // Accumulate every clock; the carry out of the low 16 bits is the output bit
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) acc <= '0;
    else             acc <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, mod_in};
  end

  assign dac_out = acc[SAMPLE_W];

endmodule

// File: rtl/audio_dsm_out.sv
// Audio output stage: captures mixer samples with gain and saturation,
// ramps attenuation for click-free mute, hard-mutes on sample underrun,
// and drives the delta-sigma modulator. Dither in the modulator is
// enabled by defining TONEGEN_DITHER_EN.
module audio_dsm_out
  import tonegen_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_valid_in,
  input  logic [1:0]          gain_in,
  input  logic                mute_in,
  output logic                dac_out,
  output logic                active_out,
  output logic                clip_out,
  output logic                underrun_out
);

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_FULL = WD_W'(TIMEOUT_CYCLES);

  state_t                     state, next_state;
  logic [3:0]                 att, next_att;
  logic signed [SAMPLE_W-1:0] held, eff;
  logic [SAMPLE_W-1:0]        u;
  logic [WD_W-1:0]            wdog;
  logic [SAMPLE_W+2:0]        shifted;
  logic                       sat_pos, sat_neg;
  logic [SAMPLE_W-1:0]        sat_sample;
  logic                       timeout_hit;

  // Shift the sample by the gain in 19 bits and clamp to the 16-bit range
  always_comb begin
    shifted    = {{3{data_in[SAMPLE_W-1]}}, data_in} << gain_in;
    sat_pos    = ~shifted[SAMPLE_W+2] & (|shifted[SAMPLE_W+1:SAMPLE_W-1]);
    sat_neg    = shifted[SAMPLE_W+2] & ~(&shifted[SAMPLE_W+1:SAMPLE_W-1]);
    sat_sample = shifted[SAMPLE_W-1:0];
    if (sat_pos)      sat_sample = 16'h7FFF;
    else if (sat_neg) sat_sample = 16'h8000;
  end

  // A strobe always beats the timeout landing in the same cycle
  assign timeout_hit = !data_valid_in && (wdog == WD_LAST);

  // Sample capture, clip pulse and underrun watchdog
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      held         <= '0;
      clip_out     <= 1'b0;
      wdog         <= '0;
      underrun_out <= 1'b0;
    end else begin
      clip_out <= 1'b0;
      if (data_valid_in) begin
        held         <= sat_sample;
        clip_out     <= sat_pos | sat_neg;
        wdog         <= '0;
        underrun_out <= 1'b0;
      end else if (timeout_hit) begin
        held         <= '0;
        wdog         <= WD_FULL;
        underrun_out <= 1'b1;
      end else if (wdog != WD_FULL) begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

  // Mute ramp transitions, evaluated only on strobes or a watchdog timeout
  always_comb begin
    next_state = state;
    next_att   = att;
    if (data_valid_in) begin
      case (state)
        MUTED: begin
          if (!mute_in) begin
            next_state = RAMP_UP;
            next_att   = ATT_MAX;
          end
        end
        RAMP_UP: begin
          if (!mute_in) begin
            if (att == 4'd1) begin
              next_state = PLAY;
              next_att   = 4'd0;
            end else begin
              next_att = att - 4'd1;
            end
          end else if (att == ATT_MAX) begin
            next_state = MUTED;
          end else begin
            next_state = RAMP_DOWN;
            next_att   = att + 4'd1;
          end
        end
        PLAY: begin
          if (mute_in) begin
            next_state = RAMP_DOWN;
            next_att   = 4'd1;
          end
        end
        RAMP_DOWN: begin
          if (mute_in) begin
            if (att == ATT_MAX) next_state = MUTED;
            else                next_att   = att + 4'd1;
          end else if (att == 4'd1) begin
            next_state = PLAY;
            next_att   = 4'd0;
          end else begin
            next_state = RAMP_UP;
            next_att   = att - 4'd1;
          end
        end
        default: begin
          next_state = MUTED;
          next_att   = ATT_MAX;
        end
      endcase
    end else if (timeout_hit) begin
      next_state = MUTED;
      next_att   = ATT_MAX;
    end
  end

  // State and attenuation registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= MUTED;
      att   <= ATT_MAX;
    end else begin
      state <= next_state;
      att   <= next_att;
    end
  end

  // Effective sample one cycle after capture: attenuated held value, or silence
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)         eff <= '0;
    else if (state == MUTED) eff <= '0;
    else                     eff <= held >>> att;
  end

  assign u          = eff ^ 16'h8000;
  assign active_out = (state != MUTED);

  dsm_mod u_dsm_mod (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .u_in       (u),
    .dac_out    (dac_out)
  );

endmodule

// File: tb/tb_audio_dsm_out.sv
// Self-checking bench for audio_dsm_out (default build, no dither).
// Capture results are predicted when each strobe is driven and queued,
// then popped and compared once the DUT has registered the strobe.
module tb_audio_dsm_out;
  import tonegen_pkg::*;

  logic        clk_in        = 1'b0;
  logic        reset_n_in    = 1'b1;
  logic [15:0] data_in       = '0;
  logic        data_valid_in = 1'b0;
  logic [1:0]  gain_in       = '0;
  logic        mute_in       = 1'b1;
  logic        dac_out, active_out, clip_out, underrun_out;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        clip;
    logic [15:0] held;
  } exp_t;

  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  audio_dsm_out #(.TIMEOUT_CYCLES(2048)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .gain_in       (gain_in),
    .mute_in       (mute_in),
    .dac_out       (dac_out),
    .active_out    (active_out),
    .clip_out      (clip_out),
    .underrun_out  (underrun_out)
  );

  // Reference for gain and saturation using plain integer arithmetic
  function automatic exp_t model_capture(input logic [15:0] d, input logic [1:0] g);
    exp_t e;
    int   v;
    v = int'($signed(d)) * (1 << g);
    e.clip = 1'b0;
    e.held = v[15:0];
    if (v > 32767) begin
      e.clip = 1'b1;
      e.held = 16'h7FFF;
    end else if (v < -32768) begin
      e.clip = 1'b1;
      e.held = 16'h8000;
    end
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One-cycle strobe; returns at the negedge after the capturing edge
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] g, input logic m);
    @(negedge clk_in);
    data_in       = d;
    gain_in       = g;
    mute_in       = m;
    data_valid_in = 1'b1;
    sb.push_back(model_capture(d, g));
    @(negedge clk_in);
    data_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_in = 1'b1;
    #2 reset_n_in = 1'b0;
    #1;
    checks++; if (dac_out !== 1'b0) $display("[TB] FAIL reset_dac got %b want 0", dac_out); else passes++;
    checks++; if (active_out !== 1'b0) $display("[TB] FAIL reset_active got %b want 0", active_out); else passes++;
    checks++; if (clip_out !== 1'b0) $display("[TB] FAIL reset_clip got %b want 0", clip_out); else passes++;
    checks++; if (underrun_out !== 1'b0) $display("[TB] FAIL reset_underrun got %b want 0", underrun_out); else passes++;
    checks++; if (dut.state !== MUTED || dut.att !== 4'd15)
      $display("[TB] FAIL reset_state got state=%0d att=%0d want 0/15", dut.state, dut.att); else passes++;
    idle(3);
  endtask

  task automatic test_mute_pattern;
    int errs = 0;
    int act_errs = 0;
    mute_in = 1'b1;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int n = 1; n <= 2100; n++) begin
      @(negedge clk_in);
      if (dac_out !== logic'(n % 2 == 0)) errs++;
      if (active_out !== 1'b0) act_errs++;
      data_in       = 16'h1234;
      data_valid_in = (n % 1024 == 500);
    end
    data_valid_in = 1'b0;
    checks++; if (errs !== 0) $display("[TB] FAIL mute_pattern bad bits %0d want 0", errs); else passes++;
    checks++; if (act_errs !== 0) $display("[TB] FAIL mute_active high cycles %0d want 0", act_errs); else passes++;
  endtask

  task automatic test_ramp_up;
    exp_t e;
    int   ones = 0;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(16'h4000, 2'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (clip_out !== e.clip || dut.held !== e.held)
        $display("[TB] FAIL ramp_up_capture clip=%b held=%h want clip=%b held=%h", clip_out, dut.held, e.clip, e.held);
      else passes++;
      if (k == 1) begin
        checks++;
        if (active_out !== 1'b1 || dut.state !== RAMP_UP || dut.att !== 4'd15)
          $display("[TB] FAIL ramp_up_first active=%b state=%0d att=%0d want 1/1/15", active_out, dut.state, dut.att);
        else passes++;
      end
      if (k == 15) begin
        checks++;
        if (dut.state !== RAMP_UP || dut.att !== 4'd1)
          $display("[TB] FAIL ramp_up_15 state=%0d att=%0d want 1/1", dut.state, dut.att);
        else passes++;
      end
      if (k == 16) begin
        checks++;
        if (dut.state !== PLAY || dut.att !== 4'd0)
          $display("[TB] FAIL ramp_up_play state=%0d att=%0d want 2/0", dut.state, dut.att);
        else passes++;
      end
      idle(8);
    end
    idle(4);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      if (dac_out === 1'b1) ones++;
    end
    checks++; if (ones !== 48) $display("[TB] FAIL density ones=%0d want 48", ones); else passes++;
  endtask

  task automatic test_gain_clip;
    exp_t        e;
    logic [15:0] d_tab [4] = '{16'h3000, 16'hE000, 16'h1234, 16'h9000};
    logic [1:0]  g_tab [4] = '{2'd2, 2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(d_tab[i], g_tab[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if (clip_out !== e.clip || dut.held !== e.held)
        $display("[TB] FAIL gain_capture_%0d clip=%b held=%h want clip=%b held=%h", i, clip_out, dut.held, e.clip, e.held);
      else passes++;
      idle(1);
      checks++; if (clip_out !== 1'b0) $display("[TB] FAIL clip_width_%0d got %b want 0", i, clip_out); else passes++;
      idle(6);
    end
    applyStimulus(16'h4000, 2'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (clip_out !== e.clip || dut.held !== e.held)
      $display("[TB] FAIL gain_restore clip=%b held=%h want clip=%b held=%h", clip_out, dut.held, e.clip, e.held);
    else passes++;
    idle(6);
  endtask

  task automatic test_ramp_down;
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(16'h4000, 2'd0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (clip_out !== e.clip || dut.held !== e.held)
        $display("[TB] FAIL ramp_down_capture clip=%b held=%h want clip=%b held=%h", clip_out, dut.held, e.clip, e.held);
      else passes++;
      if (k == 15) begin
        checks++;
        if (active_out !== 1'b1 || dut.state !== RAMP_DOWN || dut.att !== 4'd15)
          $display("[TB] FAIL ramp_down_15 active=%b state=%0d att=%0d want 1/3/15", active_out, dut.state, dut.att);
        else passes++;
      end
      if (k == 16) begin
        checks++;
        if (active_out !== 1'b0 || dut.state !== MUTED)
          $display("[TB] FAIL ramp_down_muted active=%b state=%0d want 0/0", active_out, dut.state);
        else passes++;
      end
      idle(6);
    end
  endtask

  task automatic test_ramp_reversal;
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(16'h4000, 2'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (dut.held !== e.held) $display("[TB] FAIL reup_capture held=%h want %h", dut.held, e.held); else passes++;
      idle(4);
    end
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(16'h2000, 2'd0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (dut.held !== e.held) $display("[TB] FAIL rev_down_capture held=%h want %h", dut.held, e.held); else passes++;
      idle(4);
    end
    checks++;
    if (dut.state !== RAMP_DOWN || dut.att !== 4'd5)
      $display("[TB] FAIL rev_down_5 state=%0d att=%0d want 3/5", dut.state, dut.att);
    else passes++;
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(16'h2000, 2'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (dut.held !== e.held) $display("[TB] FAIL rev_up_capture held=%h want %h", dut.held, e.held); else passes++;
      if (j == 1) begin
        checks++;
        if (dut.state !== RAMP_UP || dut.att !== 4'd4)
          $display("[TB] FAIL rev_turn state=%0d att=%0d want 1/4", dut.state, dut.att);
        else passes++;
      end
      if (j == 4) begin
        checks++;
        if (dut.state !== RAMP_UP || dut.att !== 4'd1)
          $display("[TB] FAIL rev_up_4 state=%0d att=%0d want 1/1", dut.state, dut.att);
        else passes++;
      end
      if (j == 5) begin
        checks++;
        if (dut.state !== PLAY || dut.att !== 4'd0)
          $display("[TB] FAIL rev_play state=%0d att=%0d want 2/0", dut.state, dut.att);
        else passes++;
      end
      idle(4);
    end
  endtask

  task automatic test_underrun;
    exp_t e;
    int   errs = 0;
    int   alt_errs = 0;
    logic prev = 1'b0;
    applyStimulus(16'h4000, 2'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (dut.held !== e.held) $display("[TB] FAIL underrun_last held=%h want %h", dut.held, e.held); else passes++;
    for (int k = 1; k <= 2100; k++) begin
      @(negedge clk_in);
      if (underrun_out !== logic'(k >= 2048)) errs++;
      if (k == 2048) begin
        checks++;
        if (active_out !== 1'b0 || dut.state !== MUTED || dut.held !== 16'h0000)
          $display("[TB] FAIL underrun_mute active=%b state=%0d held=%h want 0/0/0000", active_out, dut.state, dut.held);
        else passes++;
      end
      if (k > 2055 && dac_out === prev) alt_errs++;
      prev = dac_out;
    end
    checks++; if (errs !== 0) $display("[TB] FAIL underrun_timing bad cycles %0d want 0", errs); else passes++;
    checks++; if (alt_errs !== 0) $display("[TB] FAIL underrun_dac non-alternating %0d want 0", alt_errs); else passes++;
    applyStimulus(16'h1111, 2'd0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (underrun_out !== 1'b0 || dut.state !== MUTED || dut.held !== e.held)
      $display("[TB] FAIL underrun_clear underrun=%b state=%0d held=%h want 0/0/%h", underrun_out, dut.state, dut.held, e.held);
    else passes++;
    idle(4);
  endtask

  task automatic test_reset_mid_ramp;
    exp_t e;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) applyStimulus(16'h3000, 2'd2, 1'b0);
      else        applyStimulus(16'h4000, 2'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (clip_out !== e.clip || dut.held !== e.held)
        $display("[TB] FAIL midramp_capture clip=%b held=%h want clip=%b held=%h", clip_out, dut.held, e.clip, e.held);
      else passes++;
      if (k < 9) idle(4);
    end
    checks++;
    if (dut.state !== RAMP_UP || dut.att !== 4'd7)
      $display("[TB] FAIL midramp_att state=%0d att=%0d want 1/7", dut.state, dut.att);
    else passes++;
    #1 reset_n_in = 1'b0;
    #1;
    checks++;
    if (dac_out !== 1'b0 || active_out !== 1'b0 || clip_out !== 1'b0 || underrun_out !== 1'b0)
      $display("[TB] FAIL midramp_reset_outputs dac=%b active=%b clip=%b underrun=%b want 0000",
               dac_out, active_out, clip_out, underrun_out);
    else passes++;
    checks++;
    if (dut.state !== MUTED || dut.att !== 4'd15)
      $display("[TB] FAIL midramp_reset_state state=%0d att=%0d want 0/15", dut.state, dut.att);
    else passes++;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    idle(2);
    applyStimulus(16'h4000, 2'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (dut.state !== RAMP_UP || dut.att !== 4'd15 || active_out !== 1'b1 || dut.held !== e.held)
      $display("[TB] FAIL midramp_restart state=%0d att=%0d active=%b held=%h want 1/15/1/%h",
               dut.state, dut.att, active_out, dut.held, e.held);
    else passes++;
  endtask

  // Sequence the scenarios and report
  initial begin
    test_reset;
    test_mute_pattern;
    test_ramp_up;
    test_gain_clip;
    test_ramp_down;
    test_ramp_reversal;
    test_underrun;
    test_reset_mid_ramp;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout sim time exceeded, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
